combo_lock_core: RTL and testbench

Parametrised combination-lock engine for the Basys board top level. It generalises the fixed 4-digit hex lock to N digits of W bits each. It adds a retry counter with timed lockout, and lets the user reprogram the code while unlocked. Inputs are single-cycle pulses from the existing debounce blocks. Outputs drive the seven-segment driver and the LEDs.

---
 rtl/combo_lock_core.sv | 175 +++++++++++++++++
 tb/tb_combo_lock_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_core.sv
// N-digit combination lock: dial/commit digits, check against a programmable code,
// count wrong attempts and hold a timed lockout after MAX_TRIES failures.
module combo_lock_core #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = 16'h1234
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inc,
  input  logic                            dec,
  input  logic                            enter,
  input  logic                            lock,
  input  logic                            prog,
  output logic [DIGIT_W-1:0]              sel_digit,
  output logic [DIGITS*DIGIT_W-1:0]       entry,
  output logic [$clog2(DIGITS+1)-1:0]     digit_count,
  output logic [1:0]                      state,
  output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
  output logic                            alarm
);
  localparam int EW  = DIGITS * DIGIT_W;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TMW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t             stateQ, stateD;
  logic [DIGIT_W-1:0] selQ, selD;
  logic [EW-1:0]      entryQ, entryD;
  logic [CW-1:0]      countQ, countD;
  logic [TRW-1:0]     triesQ, triesD;
  logic [EW-1:0]      codeQ, codeD;
  logic [TMW-1:0]     timerQ, timerD;
  logic               checkQ, checkD;

  logic [DIGIT_W-1:0] selDialed;
  logic [EW-1:0]      entryShifted;
  logic               lastDigit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= LOCKED;
      selQ   <= '0;
      entryQ <= '0;
      countQ <= '0;
      triesQ <= TRW'(MAX_TRIES);
      codeQ  <= RESET_CODE;
      timerQ <= '0;
      checkQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      selQ   <= selD;
      entryQ <= entryD;
      countQ <= countD;
      triesQ <= triesD;
      codeQ  <= codeD;
      timerQ <= timerD;
      checkQ <= checkD;
    end
  end

  // inc and dec cancel when pulsed together
  always_comb begin
    selDialed = selQ;
    if (inc && !dec)      selDialed = selQ + DIGIT_W'(1);
    else if (dec && !inc) selDialed = selQ - DIGIT_W'(1);
  end

  assign entryShifted = {entryQ[EW-DIGIT_W-1:0], selQ};
  assign lastDigit    = (countQ == CW'(DIGITS - 1));

  always_comb begin
    stateD = stateQ;
    selD   = selQ;
    entryD = entryQ;
    countD = countQ;
    triesD = triesQ;
    codeD  = codeQ;
    timerD = timerQ;
    checkD = checkQ;

    if (checkQ) begin
      // Check cycle: every input is ignored while the full entry is judged.
      entryD = '0;
      countD = '0;
      checkD = 1'b0;
      if (entryQ == codeQ) begin
        stateD = UNLOCKED;
        triesD = TRW'(MAX_TRIES);
      end else if (triesQ > TRW'(1)) begin
        triesD = triesQ - TRW'(1);
      end else begin
        triesD = '0;
        stateD = LOCKOUT;
        timerD = TMW'(LOCKOUT_CYCLES - 1);
      end
    end else begin
      unique case (stateQ)
        LOCKED: begin
          if (lock) begin
            entryD = '0;
            countD = '0;
            selD   = '0;
          end else if (enter) begin
            entryD = entryShifted;
            countD = countQ + CW'(1);
            selD   = '0;
            checkD = lastDigit;
          end else begin
            selD = selDialed;
          end
        end
        UNLOCKED: begin
          if (lock) begin
            stateD = LOCKED;
            entryD = '0;
            countD = '0;
            selD   = '0;
          end else if (prog) begin
            stateD = PROGRAM;
            entryD = '0;
            countD = '0;
          end else begin
            selD = selDialed;
          end
        end
        PROGRAM: begin
          if (lock) begin
            stateD = UNLOCKED;
            entryD = '0;
            countD = '0;
          end else if (enter) begin
            selD = '0;
            if (lastDigit) begin
              codeD  = entryShifted;
              stateD = LOCKED;
              entryD = '0;
              countD = '0;
            end else begin
              entryD = entryShifted;
              countD = countQ + CW'(1);
            end
          end else begin
            selD = selDialed;
          end
        end
        LOCKOUT: begin
          if (timerQ == '0) begin
            stateD = LOCKED;
            triesD = TRW'(MAX_TRIES);
          end else begin
            timerD = timerQ - TMW'(1);
          end
        end
        default: stateD = LOCKED;
      endcase
    end
  end

  assign sel_digit   = selQ;
  assign entry       = entryQ;
  assign digit_count = countQ;
  assign state       = stateQ;
  assign tries_left  = triesQ;
  assign alarm       = (stateQ == LOCKOUT);
endmodule

// File: tb/tb_combo_lock_core.sv
// Directed bench for combo_lock_core: default 4x4 lock (short lockout) and a 6x3 octal variant.
module tb_combo_lock_core;
  logic clk = 1'b0;
  logic rst = 1'b0, inc = 1'b0, dec = 1'b0, enter = 1'b0, lock = 1'b0, prog = 1'b0;
  logic [3:0]  sel_digit;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic [1:0]  state;
  logic [1:0]  tries_left;
  logic        alarm;

  logic rst2 = 1'b0, inc2 = 1'b0, enter2 = 1'b0, zero2 = 1'b0;
  logic [2:0]  sel2;
  logic [17:0] entry2;
  logic [2:0]  count2;
  logic [1:0]  state2;
  logic [1:0]  tries2;
  logic        alarm2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  combo_lock_core #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(8),
                    .RESET_CODE(16'h1234)) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .enter(enter), .lock(lock), .prog(prog),
    .sel_digit(sel_digit), .entry(entry), .digit_count(digit_count), .state(state),
    .tries_left(tries_left), .alarm(alarm)
  );

  combo_lock_core #(.DIGITS(6), .DIGIT_W(3), .MAX_TRIES(3), .LOCKOUT_CYCLES(8),
                    .RESET_CODE(18'o123456)) dut2 (
    .clk(clk), .rst(rst2), .inc(inc2), .dec(zero2), .enter(enter2), .lock(zero2), .prog(zero2),
    .sel_digit(sel2), .entry(entry2), .digit_count(count2), .state(state2),
    .tries_left(tries2), .alarm(alarm2)
  );

  // Drive one cycle of inputs from a negedge; returns at the next negedge with outputs settled.
  task automatic step(input logic i, input logic d, input logic e, input logic l,
                      input logic p, input logic r);
    inc = i; dec = d; enter = e; lock = l; prog = p; rst = r;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; enter = 1'b0; lock = 1'b0; prog = 1'b0; rst = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Dial v from sel_digit==0 by the shorter direction, then commit it.
  task automatic dial_enter(input logic [3:0] v);
    if (v <= 4'd8) repeat (int'(v)) step(1, 0, 0, 0, 0, 0);
    else repeat (16 - int'(v)) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic dial_digits(input logic [15:0] c);
    for (int i = 0; i < 4; i++) dial_enter(c[15-4*i -: 4]);
  endtask

  task automatic enter_code(input logic [15:0] c);
    dial_digits(c);
    idle();
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (sel_digit !== 4'h0) begin errors++; $display("FAIL reset_sel got %h exp 0", sel_digit); end
    checks++; if (entry !== 16'h0) begin errors++; $display("FAIL reset_entry got %h exp 0", entry); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", digit_count); end
    checks++; if (tries_left !== 2'd3) begin errors++; $display("FAIL reset_tries got %0d exp 3", tries_left); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b exp 0", alarm); end
  endtask

  task automatic test_correct();
    dial_digits(16'h1234);
    checks++; if (entry !== 16'h1234) begin errors++; $display("FAIL correct_entry got %h exp 1234", entry); end
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL correct_count got %0d exp 4", digit_count); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL correct_latency got %0d exp 0", state); end
    idle();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL correct_state got %0d exp 1", state); end
    checks++; if (tries_left !== 2'd3) begin errors++; $display("FAIL correct_tries got %0d exp 3", tries_left); end
    checks++; if (entry !== 16'h0 || digit_count !== 3'd0) begin errors++;
      $display("FAIL correct_clear got entry %h count %0d exp 0 0", entry, digit_count); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL relock_state got %0d exp 0", state); end
  endtask

  task automatic test_wrap();
    step(0, 1, 0, 0, 0, 0);
    checks++; if (sel_digit !== 4'hF) begin errors++; $display("FAIL wrap_dec got %h exp f", sel_digit); end
    step(1, 0, 0, 0, 0, 0);
    checks++; if (sel_digit !== 4'h0) begin errors++; $display("FAIL wrap_inc got %h exp 0", sel_digit); end
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    checks++; if (sel_digit !== 4'h1) begin errors++; $display("FAIL inc_dec_same got %h exp 1", sel_digit); end
    step(1, 0, 1, 0, 0, 0);
    checks++; if (entry !== 16'h0001 || sel_digit !== 4'h0 || digit_count !== 3'd1) begin errors++;
      $display("FAIL enter_inc got entry %h sel %h count %0d exp 0001 0 1", entry, sel_digit, digit_count); end
    step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_lockout();
    enter_code(16'h0000);
    checks++; if (tries_left !== 2'd2) begin errors++; $display("FAIL lockout_try1 got %0d exp 2", tries_left); end
    enter_code(16'h0000);
    checks++; if (tries_left !== 2'd1) begin errors++; $display("FAIL lockout_try2 got %0d exp 1", tries_left); end
    enter_code(16'h0000);
    checks++; if (state !== 2'd3 || alarm !== 1'b1 || tries_left !== 2'd0) begin errors++;
      $display("FAIL lockout_enter got state %0d alarm %b tries %0d exp 3 1 0", state, alarm, tries_left); end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    idle();
    idle();
    checks++; if (state !== 2'd3 || sel_digit !== 4'h0 || digit_count !== 3'd0) begin errors++;
      $display("FAIL lockout_hold got state %0d sel %h count %0d exp 3 0 0", state, sel_digit, digit_count); end
    idle();
    checks++; if (state !== 2'd0 || tries_left !== 2'd3 || alarm !== 1'b0) begin errors++;
      $display("FAIL lockout_exit got state %0d tries %0d alarm %b exp 0 3 0", state, tries_left, alarm); end
  endtask

  task automatic test_reprogram();
    enter_code(16'h1234);
    step(0, 0, 0, 0, 1, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL prog_enter got %0d exp 2", state); end
    dial_enter(4'hA); dial_enter(4'hB); dial_enter(4'hC);
    checks++; if (state !== 2'd2 || entry !== 16'h0ABC) begin errors++;
      $display("FAIL prog_partial got state %0d entry %h exp 2 0abc", state, entry); end
    dial_enter(4'hD);
    checks++; if (state !== 2'd0 || entry !== 16'h0 || digit_count !== 3'd0) begin errors++;
      $display("FAIL prog_done got state %0d entry %h count %0d exp 0 0 0", state, entry, digit_count); end
    enter_code(16'h1234);
    checks++; if (state !== 2'd0 || tries_left !== 2'd2) begin errors++;
      $display("FAIL prog_oldcode got state %0d tries %0d exp 0 2", state, tries_left); end
    enter_code(16'hABCD);
    checks++; if (state !== 2'd1 || tries_left !== 2'd3) begin errors++;
      $display("FAIL prog_newcode got state %0d tries %0d exp 1 3", state, tries_left); end
    step(0, 0, 0, 0, 1, 0);
    dial_enter(4'h5); dial_enter(4'h6);
    step(0, 0, 0, 1, 0, 0);
    checks++; if (state !== 2'd1 || digit_count !== 3'd0) begin errors++;
      $display("FAIL prog_abort got state %0d count %0d exp 1 0", state, digit_count); end
    step(0, 0, 0, 1, 0, 0);
    enter_code(16'hABCD);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prog_abort_code got %0d exp 1", state); end
    step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_partial();
    enter_code(16'h0000);
    dial_enter(4'h1); dial_enter(4'h2);
    checks++; if (entry !== 16'h0012 || digit_count !== 3'd2) begin errors++;
      $display("FAIL partial_entry got %h count %0d exp 0012 2", entry, digit_count); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (entry !== 16'h0 || digit_count !== 3'd0 || tries_left !== 2'd2 || state !== 2'd0) begin errors++;
      $display("FAIL partial_clear got entry %h count %0d tries %0d state %0d exp 0 0 2 0",
               entry, digit_count, tries_left, state); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 0, 1);
    enter_code(16'h0000); enter_code(16'h0000); enter_code(16'h0000);
    idle(); idle();
    step(1, 0, 0, 0, 0, 1);
    checks++; if (state !== 2'd0 || alarm !== 1'b0 || tries_left !== 2'd3 || sel_digit !== 4'h0) begin errors++;
      $display("FAIL rst_lockout got state %0d alarm %b tries %0d sel %h exp 0 0 3 0",
               state, alarm, tries_left, sel_digit); end
    enter_code(16'h1234);
    step(0, 0, 0, 0, 1, 0);
    dial_digits(16'h5678);
    dial_digits(16'h1234);
    step(0, 0, 0, 0, 0, 1);
    checks++; if (state !== 2'd0 || entry !== 16'h0 || digit_count !== 3'd0 || tries_left !== 2'd3) begin errors++;
      $display("FAIL rst_check got state %0d entry %h count %0d tries %0d exp 0 0 0 3",
               state, entry, digit_count, tries_left); end
    idle();
    checks++; if (state !== 2'd0 || tries_left !== 2'd3) begin errors++;
      $display("FAIL rst_check_flag got state %0d tries %0d exp 0 3", state, tries_left); end
    enter_code(16'h1234);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_code_revert got %0d exp 1", state); end
    step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    dial_digits(16'h1234);
    step(1, 0, 1, 1, 1, 0);
    checks++; if (state !== 2'd1 || sel_digit !== 4'h0 || tries_left !== 2'd3) begin errors++;
      $display("FAIL check_cycle_ignore got state %0d sel %h tries %0d exp 1 0 3", state, sel_digit, tries_left); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL b2b_lock got %0d exp 0", state); end
  endtask

  task automatic test_sweep();
    for (int k = 1; k <= 6; k++) begin
      repeat (k) begin inc2 = 1'b1; @(negedge clk); inc2 = 1'b0; end
      enter2 = 1'b1; @(negedge clk); enter2 = 1'b0;
    end
    checks++; if (entry2 !== 18'o123456 || count2 !== 3'd6) begin errors++;
      $display("FAIL sweep_entry got %o count %0d exp 123456 6", entry2, count2); end
    @(negedge clk);
    checks++; if (state2 !== 2'd1 || tries2 !== 2'd3) begin errors++;
      $display("FAIL sweep_unlock got state %0d tries %0d exp 1 3", state2, tries2); end
    repeat (7) begin inc2 = 1'b1; @(negedge clk); inc2 = 1'b0; end
    checks++; if (sel2 !== 3'd7) begin errors++; $display("FAIL sweep_max got %0d exp 7", sel2); end
    inc2 = 1'b1; @(negedge clk); inc2 = 1'b0;
    checks++; if (sel2 !== 3'd0) begin errors++; $display("FAIL sweep_wrap got %0d exp 0", sel2); end
  endtask

  initial begin
    rst2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    checks++; if (state2 !== 2'd0 || sel2 !== 3'd0 || alarm2 !== 1'b0) begin errors++;
      $display("FAIL sweep_reset got state %0d sel %0d alarm %b exp 0 0 0", state2, sel2, alarm2); end
    test_reset();
    test_correct();
    test_wrap();
    test_lockout();
    test_reprogram();
    test_partial();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
